imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 169 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate decoder feeding a DEPTH-entry output FIFO. Optional macro
// IMM_GEN_PIPE_ILLEGAL_EN adds a per-entry out_illegal flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    ,
    output logic                     out_illegal
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_SH   = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        logic             illegal;
`endif
    } entry_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        dec;
    entry_t        head;
    logic [31:0]   raw;
    logic          push;
    logic          pop;

    // Decode ahead of storage; raw is a 32-bit sign-extended immediate, widened by cast.
    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        dec.fmt = FMT_NONE;
        raw     = '0;
        unique case (in_inst[6:0])
            7'b0010011: begin
                if (in_inst[13:12] == 2'b01) begin
                    dec.fmt = FMT_SH;
                    raw     = (XLEN == 64) ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]};
                end else begin
                    dec.fmt = FMT_I;
                    raw     = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                raw     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                raw     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                raw     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                raw     = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                raw     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            default: begin
                dec.fmt = FMT_NONE;
                raw     = '0;
            end
        endcase
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        if (in_inst[1:0] != 2'b11) begin
            dec.fmt = FMT_NONE;
            raw     = '0;
        end
        dec.illegal = (dec.fmt == FMT_NONE);
`endif
        dec.imm = XLEN'($signed(raw));
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready depends only on count, so a full FIFO never accepts even while popping.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Storage is zeroed by reset, so the head read shows all-zero outputs while in reset.
    assign head      = mem_q[rd_ptr_q];
    assign out_imm   = head.imm;
    assign out_fmt   = head.fmt;
    assign out_tag   = head.tag;
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != CW'(DEPTH));
    assign count     = count_q;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    assign out_illegal = head.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit/DEPTH=4 instance and a 64-bit instance,
// with directed instruction vectors and hand-computed immediates.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int W     = XLEN + 3 + TAG_W + 1;
    localparam int W64   = 64 + 3 + TAG_W + 1;
    localparam int NV    = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_inst = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        count;

    logic              in_valid64 = 1'b0;
    logic              in_ready64;
    logic [31:0]       in_inst64 = '0;
    logic [TAG_W-1:0]  in_tag64 = '0;
    logic              out_valid64;
    logic              out_ready64 = 1'b1;
    logic [63:0]       out_imm64;
    logic [2:0]        out_fmt64;
    logic [TAG_W-1:0]  out_tag64;
    logic [2:0]        count64;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    logic              out_illegal;
    logic              out_illegal64;
`endif

    imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_tag(out_tag), .count(count)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_tag(out_tag64), .count(count64)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        , .out_illegal(out_illegal64)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [W64-1:0] exp64_q[$];

    logic [31:0]     v_inst [NV];
    logic [XLEN-1:0] v_imm  [NV];
    logic [2:0]      v_fmt  [NV];
    logic            v_ill  [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the entry.
    task automatic push(input int idx, input logic [TAG_W-1:0] tag);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_inst  = v_inst[idx];
        in_tag   = tag;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back({v_imm[idx], v_fmt[idx], tag, v_ill[idx]});
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=no_accept expected=accept idx=%0d", idx);
        end
    endtask

    task automatic push64(input logic [31:0] inst, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        logic acc;
        acc        = 1'b0;
        in_valid64 = 1'b1;
        in_inst64  = inst;
        in_tag64   = tag;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready64;
            @(posedge clk);
            if (acc) exp64_q.push_back({imm, fmt, tag, 1'b0});
            #1;
        end
        in_valid64 = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push64_timeout actual=no_accept expected=accept");
        end
    endtask

    always @(negedge clk) begin : mon32
        logic [W-1:0] e;
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected actual=tag%0h expected=no_output", out_tag);
            end else begin
                e = exp_q.pop_front();
                check("mon_imm", 64'(out_imm), 64'(e[W-1 -: XLEN]));
                check("mon_fmt", 64'(out_fmt), 64'(e[TAG_W+3:TAG_W+1]));
                check("mon_tag", 64'(out_tag), 64'(e[TAG_W:1]));
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
                check("mon_illegal", 64'(out_illegal), 64'(e[0]));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon64
        logic [W64-1:0] e;
        if (rst_n && !flush && out_valid64 && out_ready64) begin
            if (exp64_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon64_unexpected actual=tag%0h expected=no_output", out_tag64);
            end else begin
                e = exp64_q.pop_front();
                check("mon64_imm", out_imm64, e[W64-1 -: 64]);
                check("mon64_fmt", 64'(out_fmt64), 64'(e[TAG_W+3:TAG_W+1]));
                check("mon64_tag", 64'(out_tag64), 64'(e[TAG_W:1]));
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
                check("mon64_illegal", 64'(out_illegal64), 64'(e[0]));
`endif
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0 && exp64_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain_q32", 64'(exp_q.size()), 64'd0);
        check("drain_q64", 64'(exp64_q.size()), 64'd0);
    endtask

    initial begin
        v_inst = '{32'hFFF00093, 32'h4030D093, 32'hFE000EE3, 32'h0010006F, 32'h00112623,
                   32'h123450B7, 32'hFFFFF117, 32'h80002083, 32'h00008067, 32'h01F09093,
                   32'h002081B3, 32'h0000007F, 32'hFFF00090};
        v_imm  = '{32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFC, 32'h00000800, 32'h0000000C,
                   32'h12345000, 32'hFFFFF000, 32'hFFFFF800, 32'h00000000, 32'h0000001F,
                   32'h00000000, 32'h00000000, 32'h00000000};
        v_fmt  = '{3'd0, 3'd5, 3'd2, 3'd4, 3'd1, 3'd3, 3'd3, 3'd0, 3'd0, 3'd5,
                   3'd7, 3'd7, 3'd7};
        v_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b1, 1'b1};

        // Reset state before any clock edge.
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Streaming decode: each push lands in an empty FIFO or overlaps a pop.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            push(i, TAG_W'(i));
            check("stream_out_valid", 64'(out_valid), 64'd1);
            check("stream_count", 64'(count), 64'd1);
        end
        tick();
        check("stream_empty", 64'(count), 64'd0);
        tick();
        tick();
        check("pop_when_empty", 64'(count), 64'd0);

        // Fill to DEPTH, hold a fifth entry, then drain in order.
        out_ready = 1'b0;
        for (int t = 1; t <= 4; t++) push(t - 1, TAG_W'(t));
        fork
            push(4, TAG_W'(5));
            begin
                @(negedge clk);
                check("full_count", 64'(count), 64'd4);
                check("full_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("full_no_bypass", 64'(in_ready), 64'd0);
            end
        join
        drain();
        tick();
        check("full_drained", 64'(count), 64'd0);

        // Asynchronous reset between edges with three entries buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(i, TAG_W'(8 + i));
        check("pre_reset_count", 64'(count), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_imm", 64'(out_imm), 64'd0);
        exp_q.delete();
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(3, TAG_W'(11));
        check("post_reset_push", 64'(count), 64'd1);
        tick();
        check("post_reset_empty", 64'(count), 64'd0);

        // Flush beats a same-cycle push.
        out_ready = 1'b0;
        push(4, TAG_W'(12));
        push(5, TAG_W'(13));
        check("pre_flush_count", 64'(count), 64'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = v_inst[6];
        in_tag   = TAG_W'(14);
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tick();
        check("flush_dropped", 64'(count), 64'd0);
        out_ready = 1'b1;
        push(7, TAG_W'(15));
        tick();

        // 64-bit instance: sign extension and 6-bit shift amounts.
        push64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd3, 4'd1);
        push64(32'h03F09093, 64'h000000000000003F, 3'd5, 4'd2);
        push64(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 4'd3);
        push64(32'h0010006F, 64'h0000000000000800, 3'd4, 4'd4);
        check("x64_count", 64'(count64), 64'd1);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
